// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: operand/result handshake bundle for shift_add_multiplier
interface shift_add_multiplier_if #(parameter int WIDTH = 32);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic valid_data;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic signed_op;
  logic ack;
  logic ready;
  logic Done_Flag;
  logic [2*WIDTH-1:0] result;
  logic [CNT_W-1:0] calc_cycles;
  modport master (output valid_data, a, b, signed_op, ack, input ready, Done_Flag, result, calc_cycles);
  modport slave (input valid_data, a, b, signed_op, ack, output ready, Done_Flag, result, calc_cycles);
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-add multiplier, one partial product per clock; define SHIFT_ADD_MULT_EARLY_EXIT_EN to leave CALC once the multiplier is exhausted
module shift_add_multiplier #(parameter int WIDTH = 32) (
  input logic Clock,
  input logic Reset,
  shift_add_multiplier_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  state_t state;
  logic [2*WIDTH-1:0] acc, mcand, acc_n, result_r;
  logic [WIDTH-1:0] mult, mult_n, a_abs, b_abs;
  logic [CNT_W-1:0] cnt, cnt_n, cycles_r;
  logic neg, last, ready_r, done_r;
  // Operand magnitudes and next-iteration datapath values
  always_comb begin
    a_abs = bus.signed_op && bus.a[WIDTH-1] ? -bus.a : bus.a;
    b_abs = bus.signed_op && bus.b[WIDTH-1] ? -bus.b : bus.b;
    acc_n = mult[0] ? acc + mcand : acc;
    mult_n = mult >> 1;
    cnt_n = cnt + 1'b1;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    last = cnt_n == CNT_W'(WIDTH) || mult_n == '0;
`else
    last = cnt_n == CNT_W'(WIDTH);
`endif
  end
  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mult <= '0;
      cnt <= '0;
      neg <= 1'b0;
      result_r <= '0;
      cycles_r <= '0;
      ready_r <= 1'b1;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.valid_data) begin
          mcand <= {{WIDTH{1'b0}}, a_abs};
          mult <= b_abs;
          neg <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc <= '0;
          cnt <= '0;
          ready_r <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          acc <= acc_n;
          mcand <= mcand << 1;
          mult <= mult_n;
          cnt <= cnt_n;
          if (last) begin
            result_r <= neg ? -acc_n : acc_n;
            cycles_r <= cnt_n;
            done_r <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (bus.ack) begin
          done_r <= 1'b0;
          ready_r <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          ready_r <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.ready = ready_r;
  assign bus.Done_Flag = done_r;
  assign bus.result = result_r;
  assign bus.calc_cycles = cycles_r;
endmodule
